// File: rtl/servo_pkg.sv
// ============================================================================
// servo_pkg : shared widths, default setpoints and FSM state type for the
//             servo setpoint ramp.
// Rev 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

   localparam int N_W = 10;

   localparam int c_N_RESET = 150;
   localparam int c_N_MIN   = 100;
   localparam int c_N_MAX   = 200;
   localparam int c_TGT_00  = 153;
   localparam int c_TGT_01  = 130;
   localparam int c_TGT_10  = 170;
   localparam int c_TGT_11  = 130;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_t;

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// sw_debounce : 2-flop synchronizer followed by a stable-for-N-cycles filter.
// Rev 1.0
// ============================================================================
`default_nettype none

module sw_debounce
   import servo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int WIDTH           = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cand  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         // Any change restarts the stability window; the count saturates once full.
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt == c_CNT_LAST) begin
            r_acc  <= r_cand;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign dout = r_acc;

endmodule

`default_nettype wire

// File: rtl/servo_setpoint_ramp.sv
// ============================================================================
// servo_setpoint_ramp : debounced switch code -> clamped target width, slewed
//                       into the PWM setpoint N once per frame.
// Build option: SERVO_RAMP_EN (defined = bounded slew, undefined = one-step landing)
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_setpoint_ramp
   import servo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int STEP            = 1,
   parameter int N_RESET         = c_N_RESET,
   parameter int N_MIN           = c_N_MIN,
   parameter int N_MAX           = c_N_MAX,
   parameter int TGT_00          = c_TGT_00,
   parameter int TGT_01          = c_TGT_01,
   parameter int TGT_10          = c_TGT_10,
   parameter int TGT_11          = c_TGT_11
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [1:0]     SW,
   input  logic           frame_tick,
   output logic [N_W-1:0] N,
   output logic           n_update,
   output logic           busy
);

   // Without slewing the landing threshold exceeds any possible |diff| (max 2^N_W-1).
`ifdef SERVO_RAMP_EN
   localparam logic [N_W:0] c_STEP_LIM = (N_W+1)'(STEP);
`else
   localparam logic [N_W:0] c_STEP_LIM = (N_W+1)'(STEP | (1 << N_W));
`endif

   logic [1:0]        w_sw_db;
   logic [N_W-1:0]    w_tgt_raw;
   logic [N_W-1:0]    w_target;
   logic signed [N_W:0] w_diff;
   logic [N_W:0]      w_mag;
   logic              w_near;
   logic [N_W-1:0]    w_next_n;

   ramp_state_t       r_state;
   logic [N_W-1:0]    r_n;
   logic              r_n_update;
   logic              r_busy;

   sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WIDTH           (2)
   ) u_sw_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (SW),
      .dout    (w_sw_db)
   );

   always_comb begin
      w_tgt_raw = N_W'(TGT_00);
      case (w_sw_db)
         2'b00:   w_tgt_raw = N_W'(TGT_00);
         2'b01:   w_tgt_raw = N_W'(TGT_01);
         2'b10:   w_tgt_raw = N_W'(TGT_10);
         default: w_tgt_raw = N_W'(TGT_11);
      endcase
   end

   assign w_target = (w_tgt_raw < N_W'(N_MIN)) ? N_W'(N_MIN) :
                     (w_tgt_raw > N_W'(N_MAX)) ? N_W'(N_MAX) : w_tgt_raw;

   assign w_diff   = $signed({1'b0, w_target}) - $signed({1'b0, r_n});
   assign w_mag    = w_diff[N_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
   assign w_near   = (w_mag <= c_STEP_LIM);
   assign w_next_n = w_near      ? w_target :
                     !w_diff[N_W] ? r_n + N_W'(STEP) : r_n - N_W'(STEP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_n        <= N_W'(N_RESET);
         r_n_update <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_n_update <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_target != r_n) begin
                  r_state <= RAMP;
                  r_busy  <= 1'b1;
               end
            end
            RAMP: begin
               if (frame_tick) begin
                  r_n        <= w_next_n;
                  r_n_update <= (w_next_n != r_n);
                  if (w_near) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign N        = r_n;
   assign n_update = r_n_update;
   assign busy     = r_busy;

endmodule

`default_nettype wire

// File: doc/servo_setpoint_ramp.md
Name: servo_setpoint_ramp

Overview:
- Upstream stage of the servo PWM generator.
- Turns the raw 2-bit operator switch input into the pulse-width setpoint N (units of 10 us ticks) that the PWM comparator consumes.
- Synchronizes and debounces the switches, maps them to a target width, and slews N toward the target by a bounded step per PWM frame, so the servo never sees a jump or a mid-frame change.

Parameters:
- DEBOUNCE_CYCLES, 500000: clk cycles SW must be stable before acceptance (10 ms at 50 MHz).
- STEP, 1: maximum change of N per frame.
- N_RESET, 150: N value at reset (servo centre).
- N_MIN, 100: lower clamp on target.
- N_MAX, 200: upper clamp on target.
- TGT_00 / TGT_01 / TGT_10 / TGT_11, 153 / 130 / 170 / 130: target widths per debounced switch code.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- SW, input, 2: raw, asynchronous switch inputs.
- frame_tick, input, 1: one-clk pulse at the start of each PWM period (counter wrap to 1), supplied by the PWM stage.
- N, output, 10: current pulse-width setpoint, registered.
- n_update, output, 1: one-clk pulse in the cycle N takes a new value.
- busy, output, 1: high while N != target.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. On reset: N=N_RESET, n_update=0, busy=0, state=IDLE, synchronizer flops=0, debounce counter=0, accepted switch code=2'b00.
- Synchronizer: 2-flop synchronizer on SW, so input-to-debouncer latency is 2 cycles.
- Debounce:
  - If the synced value differs from the candidate: candidate <= synced, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: accepted <= candidate; cnt holds.
  - Else: cnt += 1.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Target: combinational lookup of the accepted code to a TGT_xx value, then clamped to [N_MIN, N_MAX]. Target is 10 bits unsigned.
- FSM IDLE:
  - busy=0.
  - If target != N, go to RAMP on the next cycle; busy asserts in the same cycle as the state change.
- FSM RAMP:
  - busy=1. Act only on frame_tick.
  - If |target-N| <= STEP: N <= target, then go to IDLE.
  - Else if target > N: N <= N+STEP. Else: N <= N-STEP.
  - Compute the difference with 11-bit signed arithmetic; N never under- or overflows.
- Update timing: N changes only in the cycle after a sampled frame_tick. n_update pulses exactly in that cycle, when N actually changes.
- Target changes mid-ramp: the new target is used at the very next frame_tick, and direction is recomputed, so reversal is allowed.
- frame_tick while in IDLE: ignored. frame_tick held high continuously: N steps every cycle (legal, not filtered).
- Target equals N on entry to RAMP: returns to IDLE with no n_update.
- Reset asserted mid-ramp: N returns to N_RESET immediately and asynchronously. After release, with SW=00, the block ramps toward TGT_00.

Optional Feature:
- Macro: SERVO_RAMP_EN.
- Defined: slew behaviour as specified above.
- Undefined: RAMP always lands in a single step, i.e. N <= target at the next frame_tick, then IDLE. Debounce, clamp, and n_update/busy timing are unchanged.

Decomposition:
- Package servo_pkg:
  - N_W=10.
  - Default constants for N_RESET, N_MIN, N_MAX, and the TGT_xx values.
  - Typedef ramp_state_t {IDLE, RAMP}.
- One sub-module: sw_debounce, holding the synchronizer plus debounce counter. Parameter DEBOUNCE_CYCLES and WIDTH=2; ports clk, reset_n, din, dout.

Test Plan (bench overrides DEBOUNCE_CYCLES=4; frame_tick every 20 clk):
- Release reset with SW=00 -> N stays 150 until the first frame_tick, then 151, 152, 153 on three consecutive frames; three n_update pulses; busy falls with the final step.
- Hold SW=10 -> after 2+4 cycles target=170; N increments by 1 per frame only, is constant between ticks, and reaches 170 after 17 frames (from 153); busy then 0.
- Glitch SW from 00 to 01 for 3 cycles, then back -> accepted code stays 00, no n_update, N unchanged at 153.
- During the ramp at N=160, set SW=01 -> the next frame gives N=159, descending to 130; no frame ever shows a step larger than 1.
- STEP=4 override, from 150 to target 153 -> a single frame makes N=153, no overshoot, IDLE.
- Assert reset_n low while N=165 in RAMP -> N=150, busy=0 in the same cycle without waiting for clk; after release it ramps to 153. Also run this with SERVO_RAMP_EN undefined: the 153-to-170 change completes in one frame.
